// File: rtl/ram_port_arbiter_64bits.sv
// rtl/ram_port_arbiter_64bits.sv - round-robin two-requester arbiter and sequencer for a 64-bit x 128 RAM
// Optional zero-fill sweep sequencer enabled by defining RAM_ARB_CLEAR_SWEEP_EN.
module ram_port_arbiter_64bits #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  async_clear_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic                  last;
    logic                  pipe_valid;
    logic                  pipe_owner;
    logic                  arb_en;
    logic                  acc0;
    logic                  acc1;
    logic                  accept;
    logic                  sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef RAM_ARB_CLEAR_SWEEP_EN
    typedef enum logic {IDLE_ARB, CLEAR} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    assign arb_en = async_clear_n && (state == IDLE_ARB);
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clear_busy         = 1'b0;
    assign arb_en             = async_clear_n;
`endif

    // On a conflict the requester that did not win most recently is served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_en) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign acc0      = req0 & gnt0;
    assign acc1      = req1 & gnt1;
    assign accept    = acc0 | acc1;
    assign sel       = acc1;
    assign sel_we    = sel ? we1 : we0;
    assign sel_addr  = sel ? addr1 : addr0;
    assign sel_wdata = sel ? wdata1 : wdata0;

    assign rdata0 = ram_q;
    assign rdata1 = ram_q;

    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            ram_we         <= 1'b0;
            ram_data       <= '0;
            ram_write_addr <= '0;
            ram_read_addr  <= '0;
            rvalid0        <= 1'b0;
            rvalid1        <= 1'b0;
            pipe_valid     <= 1'b0;
            pipe_owner     <= 1'b0;
            last           <= 1'b1;
`ifdef RAM_ARB_CLEAR_SWEEP_EN
            state          <= IDLE_ARB;
            sweep_cnt      <= '0;
            clear_busy     <= 1'b0;
`endif
        end else begin
            // Second stage of the {valid, owner} pipe lines up with the RAM's registered read address.
            rvalid0    <= pipe_valid && !pipe_owner;
            rvalid1    <= pipe_valid && pipe_owner;
            pipe_valid <= accept && !sel_we;
            pipe_owner <= sel;
            ram_we     <= 1'b0;
            if (accept) begin
                ram_we         <= sel_we;
                ram_write_addr <= sel_addr;
                ram_read_addr  <= sel_addr;
                ram_data       <= sel_wdata;
                last           <= sel;
            end
`ifdef RAM_ARB_CLEAR_SWEEP_EN
            case (state)
                IDLE_ARB: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        sweep_cnt  <= '0;
                    end
                end
                CLEAR: begin
                    ram_we         <= 1'b1;
                    ram_data       <= '0;
                    ram_write_addr <= sweep_cnt;
                    // Explicit end detection so the counter never rolls into a second pass.
                    if (sweep_cnt == LAST_ADDR) begin
                        state      <= IDLE_ARB;
                        clear_busy <= 1'b0;
                        sweep_cnt  <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
            endcase
`endif
        end
    end

endmodule

// File: doc/ram_port_arbiter_64bits.md
Name: ram_port_arbiter_64bits

Overview:
- Two-requester arbiter and sequencer for one single-clock 64-bit x 128-entry RAM.
- The RAM has a registered read address and a combinational q from mem[addr_reg].
- The arbiter multiplexes both multiplier-stage requesters onto the RAM write and read port, applies round-robin fairness and returns read data with a fixed latency.
- An optional sweep sequencer zero-fills the RAM through the normal write port.

Parameters:
DATA_WIDTH, 64, RAM word width
ADDR_WIDTH, 7, RAM address width (depth 2**ADDR_WIDTH)

Ports:
clk  input  1  single system clock, rising edge
async_clear_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 transaction request
we0  input  1  requester 0 transaction type: 1 write, 0 read
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  requester 0 grant (combinational)
rvalid0  output  1  requester 0 read data valid
rdata0  output  DATA_WIDTH  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as requester 0, for requester 1
clear_start  input  1  pulse that starts the zero-fill sweep
clear_busy  output  1  sweep in progress
ram_data  output  DATA_WIDTH  to RAM data
ram_write_addr  output  ADDR_WIDTH  to RAM write_addr
ram_read_addr  output  ADDR_WIDTH  to RAM read_addr
ram_we  output  1  to RAM we
ram_q  input  DATA_WIDTH  from RAM q

Behaviour:
- Reset: async_clear_n low immediately forces the following.
  - ram_we=0, ram_data=0, ram_write_addr=0, ram_read_addr=0.
  - rvalid0/1=0, clear_busy=0, sweep counter=0.
  - Round-robin pointer last=1, so requester 0 wins the first conflict.
  - gnt0/1 held 0 while reset is asserted.
- States: IDLE_ARB (normal arbitration), CLEAR (sweep).
- Grant rules in IDLE_ARB, combinational:
  - Only one requesting: that requester is granted.
  - Both requesting: grant the requester not equal to last.
  - last updates to the granted index on each granting edge.
- Handshake:
  - A transaction is accepted on a rising edge where req&gnt is high.
  - The requester holds we/addr/wdata stable while req is high and not granted.
  - Back-to-back acceptance is allowed every cycle.
  - Both requesting continuously gives strict alternation 0,1,0,1...
- RAM-side pipeline: on acceptance at edge E, registered at E:
  - ram_we <= we of the accepted transaction.
  - ram_write_addr <= addr and ram_read_addr <= addr.
  - ram_data <= wdata.
  - Cycles with no acceptance: ram_we <= 0, addresses and data hold.
- Read latency:
  - Read accepted at edge E: RAM captures the address at E+1.
  - rvalid of the granted requester is high for exactly the cycle after E+1, i.e. 2 cycles after acceptance.
  - rdata0 = rdata1 = ram_q unconditionally; meaningful only when the matching rvalid is high.
  - Writes produce no response.
- Ordering:
  - Write at edge E followed by a read of the same address accepted at E+1 returns the new data.
  - Read and write to the same address accepted at the same edge is impossible (single grant).
- Ownership: at most one rvalid is high per cycle; a 2-deep shift register of {valid, owner} tracks this.
- CLEAR transitions and behaviour (with the macro):
  - clear_start high in IDLE_ARB moves to CLEAR at the next edge. That edge still accepts a granted request.
  - In CLEAR: gnt0/1=0.
  - Each cycle: ram_we=1, ram_data=0, ram_write_addr=counter; the counter increments 0..2**ADDR_WIDTH-1.
  - After address 2**ADDR_WIDTH-1 is written, return to IDLE_ARB with clear_busy=0.
  - clear_busy is high for exactly 2**ADDR_WIDTH cycles.
  - clear_start during CLEAR is ignored.
  - Reads in flight when CLEAR starts still complete with normal rvalid timing.
  - Reset mid-sweep aborts it; the RAM content is left partially cleared.
- Address wrap: the counter is ADDR_WIDTH bits; the last address is detected explicitly, with no modulo rollover into a second sweep.

Optional Feature:
- Macro: RAM_ARB_CLEAR_SWEEP_EN.
- Defined: CLEAR state and sweep counter are implemented as in Behaviour.
- Undefined:
  - The CLEAR state and counter are removed.
  - clear_start is ignored and clear_busy is tied 0.
  - The block is pure arbitration.
- Ports exist in both builds.

Test Plan:
- Reset then req0 write addr 5 data 0xDEAD_BEEF_0000_0001 -> gnt0=1, next cycle ram_we=1, ram_write_addr=5; req0 read addr 5 -> rvalid0 high 2 cycles after acceptance, rdata0=0xDEAD_BEEF_0000_0001.
- req0 and req1 both held high for 6 cycles, reads addr 1 and 2 -> grants 0,1,0,1,0,1; rvalid alternates 0/1 from the third cycle, no cycle with both rvalids.
- req1 write addr 127 data 0x1 at edge E, req0 read addr 127 accepted at E+1 -> rdata0=0x1 with rvalid0.
- (macro on) fill addr 0..3 with nonzero data, pulse clear_start -> clear_busy high exactly 128 cycles, gnt0/1=0 throughout, then read addr 0..3 -> all 0.
- Pull async_clear_n low during a sweep at counter 40 -> all outputs are their reset values immediately; after release a req0 grant occurs and clear_busy=0.
- (macro off) pulse clear_start while req0 is high -> gnt0 stays 1, clear_busy stays 0.
